ob_fill_ctrl: RTL and testbench
===============================

# ob_fill_ctrl

Upstream fill-and-readout controller for the 64-bit output buffer in the SRAM in-memory-compute datapath. Packs successive 16-bit sense-amp results into four lanes, tracks fill level and overflow, and runs the Wishbone read handshake. During a read it drives the 3-bit select code for the SA/OB output mux, so 32-bit Wishbone reads return raw SA data, the low OB half or the high OB half.

## Interface
Parameters:
- WIDTH_SA, 16, sense-amp word width; lane width
- WIDTH_OB, 64, output buffer width; lane count is WIDTH_OB/WIDTH_SA = 4

Ports:
- wb_clk_i  in  1  single clock, rising edge
- wb_rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous buffer clear
- sa_valid  in  1  one-cycle strobe: sa_data holds a new result
- sa_data  in  WIDTH_SA  sense-amp result
- rd_req  in  1  Wishbone read strobe; held until rd_ack
- rd_sel  in  2  read target: 00 raw SA, 01 OB[31:0], 10 OB[63:32], 11 invalid
- sa_hold  out  WIDTH_SA  last captured SA word; feeds the mux sa_data
- ob_data  out  WIDTH_OB  packed buffer; feeds the mux ob_data
- ob_count  out  3  filled lanes, 0..4
- ob_full  out  1  ob_count == 4
- overflow  out  1  sticky: a sample was dropped
- mux_sel  out  3  mux select: 100 SA, 001 OB low, 010 OB high, 000 idle
- rd_ack  out  1  one-cycle read acknowledge

## Operation
- Reset (wb_rst_n low, asynchronous): every output is 0. The read FSM goes to R_IDLE.
- Fill: on sa_valid with ob_count < 4:
  - sa_data is written to lane ob_count, at bits [16*k+15:16*k].
  - ob_count increments.
  - Other lanes keep their values.
- Full: sa_valid with ob_count == 4 drops the sample and sets overflow. ob_data and ob_count do not change.
- sa_hold captures sa_data on every sa_valid, whether or not the buffer is full or clear is asserted.
- clear:
  - ob_data, ob_count and overflow go to 0.
  - It takes priority over any simultaneous sa_valid write into the buffer. sa_hold still updates.
- Read FSM:
  - R_IDLE: mux_sel = 000 and rd_ack = 0. If rd_req = 1, latch rd_sel and go to R_SEL.
  - R_SEL: mux_sel is decoded from the latched rd_sel (00→100, 01→001, 10→010, 11→000). Go to R_ACK.
  - R_ACK: mux_sel is held and rd_ack = 1. Go to R_IDLE unconditionally.
  - rd_req is not sampled in R_SEL or R_ACK. A rd_req still high in the R_IDLE cycle after the ack is a new request.
- Auto-release: when R_ACK completes for latched rd_sel = 10 while ob_full = 1, ob_count goes to 0 and overflow is cleared. ob_data is retained until lanes are overwritten.
  - If sa_valid arrives in the same cycle, the sample goes into lane 0 and ob_count = 1.
  - If clear arrives in the same cycle, clear takes priority.
- Fill writes may occur during R_SEL and R_ACK. The downstream mux shows registered ob_data as it stands in the R_ACK cycle.
- Invalid rd_sel = 11 still completes the handshake with mux_sel = 000, so the read returns 0.

## Timing
- All state is registered; no combinational path from inputs to outputs.
- Fill latency: sa_valid sampled at edge N → ob_data, ob_count, ob_full, overflow and sa_hold are valid after edge N.
- Read latency: rd_req sampled at edge N in R_IDLE:
  - mux_sel is valid after N.
  - rd_ack is high from N+1 to N+2, one cycle only.
  - mux_sel returns to 000 after N+2.
  - Minimum spacing between acks is 3 cycles.
- Reset asserted mid-read: rd_ack and mux_sel drop immediately (asynchronously). No ack is issued after reset release unless rd_req is sampled again.
- Reset release: the first active edge may capture sa_valid and rd_req.

## Test plan
- Fill: 4× sa_valid with 0x1111, 0x2222, 0x3333, 0x4444 → ob_data = 0x4444_3333_2222_1111, ob_count = 4, ob_full = 1, overflow = 0.
- Overflow: a fifth sa_valid with 0x5555 → ob_data unchanged, overflow = 1, sa_hold = 0x5555. Then clear together with sa_valid 0x6666 → ob_data = 0, ob_count = 0, overflow = 0, sa_hold = 0x6666.
- Readout on the full buffer from the fill case:
  - rd_sel = 01 → mux_sel = 001 one cycle after sampling, rd_ack at +2 cycles.
  - rd_sel = 10 → mux_sel = 010. After the ack, ob_count = 0 and ob_data is retained.
- Handshake:
  - rd_sel = 00 → mux_sel = 100.
  - rd_sel = 11 → mux_sel = 000 and rd_ack still pulses.
  - rd_req held high continuously → acks 3 cycles apart, each exactly 1 cycle wide.
- Simultaneous: sa_valid 0xAAAA in the R_ACK cycle of an upper-half read with a full buffer → ob_count = 1, ob_data[15:0] = 0xAAAA.
- Reset: wb_rst_n pulsed low during R_SEL with ob_count = 2 → all outputs 0 asynchronously, no rd_ack after release.

Source files
------------

// File: rtl/ob_fill_ctrl_if.sv
// Sense-amp fill / Wishbone readout bundle between the output-buffer controller and its host.
// The slave side is the controller; the master side drives strobes and observes buffer state.
interface ob_fill_ctrl_if #(
  parameter int WIDTH_SA = 16,
  parameter int WIDTH_OB = 64
);
  logic                clear;
  logic                sa_valid;
  logic [WIDTH_SA-1:0] sa_data;
  logic                rd_req;
  logic [1:0]          rd_sel;
  logic [WIDTH_SA-1:0] sa_hold;
  logic [WIDTH_OB-1:0] ob_data;
  logic [2:0]          ob_count;
  logic                ob_full;
  logic                overflow;
  logic [2:0]          mux_sel;
  logic                rd_ack;

  modport master (
    output clear, sa_valid, sa_data, rd_req, rd_sel,
    input  sa_hold, ob_data, ob_count, ob_full, overflow, mux_sel, rd_ack
  );

  modport slave (
    input  clear, sa_valid, sa_data, rd_req, rd_sel,
    output sa_hold, ob_data, ob_count, ob_full, overflow, mux_sel, rd_ack
  );
endinterface

// File: rtl/ob_fill_ctrl.sv
// Output-buffer fill controller: packs sense-amp words into lanes, tracks fill/overflow,
// and sequences the Wishbone read handshake that steers the SA/OB output mux.
module ob_fill_ctrl #(
  parameter int WIDTH_SA = 16,
  parameter int WIDTH_OB = 64
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n,
  ob_fill_ctrl_if.slave   bus
);

  localparam int         LANES    = WIDTH_OB / WIDTH_SA;
  localparam logic [2:0] FULL_CNT = 3'(LANES);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_SEL  = 2'd1,
    R_ACK  = 2'd2
  } rd_state_t;

  rd_state_t           state_q;
  rd_state_t           state_d;
  logic [1:0]          sel_q;
  logic [2:0]          mux_sel_c;
  logic                rd_ack_c;

  logic [WIDTH_SA-1:0] hold_q;
  logic [WIDTH_OB-1:0] data_q;
  logic [2:0]          cnt_q;
  logic                ovf_q;
  logic                full_c;
  logic                release_c;
  logic [2:0]          base_cnt;

  // Read target to one-hot mux select; the invalid code parks the mux so the read returns 0.
  function automatic logic [2:0] decode_sel(input logic [1:0] sel);
    case (sel)
      2'b00:   return 3'b100;
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= R_IDLE;
      sel_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == R_IDLE && bus.rd_req) begin
        sel_q <= bus.rd_sel;
      end
    end
  end

  // rd_req is only looked at in R_IDLE, which spaces acks at least three cycles apart.
  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:  if (bus.rd_req) state_d = R_SEL;
      R_SEL:   state_d = R_ACK;
      R_ACK:   state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    mux_sel_c = 3'b000;
    rd_ack_c  = 1'b0;
    case (state_q)
      R_SEL: mux_sel_c = decode_sel(sel_q);
      R_ACK: begin
        mux_sel_c = decode_sel(sel_q);
        rd_ack_c  = 1'b1;
      end
      default: ;
    endcase
  end

  assign full_c    = (cnt_q == FULL_CNT);
  // Reading the upper half of a full buffer hands it back for refill at the end of the ack.
  assign release_c = (state_q == R_ACK) && (sel_q == 2'b10) && full_c;
  assign base_cnt  = release_c ? 3'd0 : cnt_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      hold_q <= '0;
      data_q <= '0;
      cnt_q  <= 3'd0;
      ovf_q  <= 1'b0;
    end else begin
      if (bus.sa_valid) begin
        hold_q <= bus.sa_data;
      end
      if (bus.clear) begin
        data_q <= '0;
        cnt_q  <= 3'd0;
        ovf_q  <= 1'b0;
      end else begin
        if (release_c) begin
          cnt_q <= 3'd0;
          ovf_q <= 1'b0;
        end
        if (bus.sa_valid) begin
          if (base_cnt < FULL_CNT) begin
            for (int k = 0; k < LANES; k++) begin
              if (base_cnt == 3'(k)) begin
                data_q[k*WIDTH_SA +: WIDTH_SA] <= bus.sa_data;
              end
            end
            cnt_q <= base_cnt + 3'd1;
          end else begin
            ovf_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.sa_hold  = hold_q;
  assign bus.ob_data  = data_q;
  assign bus.ob_count = cnt_q;
  assign bus.ob_full  = full_c;
  assign bus.overflow = ovf_q;
  assign bus.mux_sel  = mux_sel_c;
  assign bus.rd_ack   = rd_ack_c;

endmodule

// File: tb/tb_ob_fill_ctrl.sv
// Scoreboard bench for ob_fill_ctrl: directed test-plan sequences followed by random traffic,
// all compared against a lane/queue reference model kept in the bench.
module tb_ob_fill_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ob_fill_ctrl_if #(.WIDTH_SA(16), .WIDTH_OB(64)) bus ();

  ob_fill_ctrl #(.WIDTH_SA(16), .WIDTH_OB(64)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: four lanes, a fill count, a sticky drop flag and a log of accepted reads.
  logic [15:0] m_lanes [4];
  int          m_cnt;
  logic        m_ovf;
  logic [15:0] m_hold;
  logic        m_busy;
  int          m_acc;
  logic [1:0]  m_sel;
  int          ecnt = 0;
  logic [1:0]  sb_q [$];

  function automatic logic [2:0] exp_mux_of(input logic [1:0] s);
    case (s)
      2'b00:   return 3'b100;
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] rdword(input logic [2:0] ms, input logic [15:0] h, input logic [63:0] d);
    case (ms)
      3'b100:  return {16'h0000, h};
      3'b001:  return d[31:0];
      3'b010:  return d[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [63:0] model_data();
    return {m_lanes[3], m_lanes[2], m_lanes[1], m_lanes[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_lanes[i] = 16'h0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_hold = 16'h0;
    m_busy = 1'b0;
    m_acc  = -10;
    m_sel  = 2'b00;
    sb_q.delete();
  endtask

  // One active edge of the model, using the inputs the DUT samples on that edge.
  task automatic model_edge();
    logic rel;
    ecnt++;
    rel = m_busy && (ecnt == m_acc + 2) && (m_sel == 2'b10) && (m_cnt == 4);
    if (bus.rd_req && !(m_busy && ecnt <= m_acc + 2)) begin
      m_busy = 1'b1;
      m_acc  = ecnt;
      m_sel  = bus.rd_sel;
      sb_q.push_back(bus.rd_sel);
    end
    if (bus.sa_valid) m_hold = bus.sa_data;
    if (bus.clear) begin
      for (int i = 0; i < 4; i++) m_lanes[i] = 16'h0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      if (rel) begin
        m_cnt = 0;
        m_ovf = 1'b0;
      end
      if (bus.sa_valid) begin
        if (m_cnt < 4) begin
          m_lanes[m_cnt] = bus.sa_data;
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present inputs, let the DUT and model take one edge, return at the following negedge.
  task automatic step(input logic v, input logic [15:0] d, input logic clr,
                      input logic req, input logic [1:0] sel);
    bus.sa_valid = v;
    bus.sa_data  = d;
    bus.clear    = clr;
    bus.rd_req   = req;
    bus.rd_sel   = sel;
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic fill4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    step(1'b1, a, 1'b0, 1'b0, 2'b00);
    step(1'b1, b, 1'b0, 1'b0, 2'b00);
    step(1'b1, c, 1'b0, 1'b0, 2'b00);
    step(1'b1, d, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic do_read(input logic [1:0] sel, input logic [2:0] exp_mux);
    step(1'b0, 16'h0, 1'b0, 1'b1, sel);
    chk("read_sel_mux", 64'(bus.mux_sel), 64'(exp_mux));
    chk("read_sel_noack", 64'(bus.rd_ack), 64'd0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 2'b00);
    chk("read_ack_mux", 64'(bus.mux_sel), 64'(exp_mux));
    chk("read_ack", 64'(bus.rd_ack), 64'd1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 2'b00);
    chk("read_done_mux", 64'(bus.mux_sel), 64'd0);
    chk("read_done_ack", 64'(bus.rd_ack), 64'd0);
  endtask

  // Monitor: every cycle compares buffer state and handshake timing; every ack pops the scoreboard.
  initial begin
    logic [1:0]  s;
    logic [63:0] ed;
    forever begin
      @(negedge clk);
      ed = model_data();
      chk("ob_data", bus.ob_data, ed);
      chk("ob_count", 64'(bus.ob_count), 64'(m_cnt));
      chk("ob_full", 64'(bus.ob_full), 64'(m_cnt == 4));
      chk("overflow", 64'(bus.overflow), 64'(m_ovf));
      chk("sa_hold", 64'(bus.sa_hold), 64'(m_hold));
      chk("rd_ack_timing", 64'(bus.rd_ack), 64'(m_busy && (ecnt == m_acc + 1)));
      chk("mux_sel_timing", 64'(bus.mux_sel),
          (m_busy && (ecnt == m_acc || ecnt == m_acc + 1)) ? 64'(exp_mux_of(m_sel)) : 64'd0);
      if (bus.rd_ack === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_spurious_ack: got rd_ack=1 expected no read outstanding (t=%0t)", $time);
        end else begin
          s = sb_q.pop_front();
          chk("sb_mux", 64'(bus.mux_sel), 64'(exp_mux_of(s)));
          chk("sb_rdata", 64'(rdword(bus.mux_sel, bus.sa_hold, bus.ob_data)),
              64'(rdword(exp_mux_of(s), m_hold, ed)));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acks [$];
    int          nack;
    logic [63:0] snap;

    model_reset();
    rst_n        = 1'b0;
    bus.sa_valid = 1'b0;
    bus.sa_data  = 16'h0;
    bus.clear    = 1'b0;
    bus.rd_req   = 1'b0;
    bus.rd_sel   = 2'b00;
    #1;
    chk("rst_ob_data", bus.ob_data, 64'd0);
    chk("rst_ob_count", 64'(bus.ob_count), 64'd0);
    chk("rst_mux_ack", 64'({bus.mux_sel, bus.rd_ack, bus.ob_full, bus.overflow}), 64'd0);
    chk("rst_sa_hold", 64'(bus.sa_hold), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Fill and overflow.
    fill4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    chk("fill_data", bus.ob_data, 64'h4444_3333_2222_1111);
    chk("fill_count", 64'(bus.ob_count), 64'd4);
    chk("fill_full", 64'(bus.ob_full), 64'd1);
    chk("fill_ovf", 64'(bus.overflow), 64'd0);
    step(1'b1, 16'h5555, 1'b0, 1'b0, 2'b00);
    chk("ovf_data", bus.ob_data, 64'h4444_3333_2222_1111);
    chk("ovf_flag", 64'(bus.overflow), 64'd1);
    chk("ovf_hold", 64'(bus.sa_hold), 64'h5555);

    // Readout of the full buffer; the upper-half read releases it.
    do_read(2'b01, 3'b001);
    do_read(2'b10, 3'b010);
    chk("release_count", 64'(bus.ob_count), 64'd0);
    chk("release_data", bus.ob_data, 64'h4444_3333_2222_1111);
    chk("release_ovf", 64'(bus.overflow), 64'd0);

    // Clear wins over a simultaneous sample, but sa_hold still captures it.
    fill4(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    step(1'b1, 16'h0505, 1'b0, 1'b0, 2'b00);
    step(1'b1, 16'h6666, 1'b1, 1'b0, 2'b00);
    chk("clear_data", bus.ob_data, 64'd0);
    chk("clear_count", 64'(bus.ob_count), 64'd0);
    chk("clear_ovf", 64'(bus.overflow), 64'd0);
    chk("clear_hold", 64'(bus.sa_hold), 64'h6666);

    // Handshake targets.
    do_read(2'b00, 3'b100);
    do_read(2'b11, 3'b000);

    // Continuous rd_req: acks every third cycle, one cycle wide.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b1, 2'b01);
      if (bus.rd_ack === 1'b1) acks.push_back(ecnt);
    end
    repeat (3) step(1'b0, 16'h0, 1'b0, 1'b0, 2'b00);
    chk("held_ack_count", 64'(acks.size()), 64'd3);
    if (acks.size() == 3) begin
      chk("held_ack_gap1", 64'(acks[1] - acks[0]), 64'd3);
      chk("held_ack_gap2", 64'(acks[2] - acks[1]), 64'd3);
    end

    // Sample landing in the R_ACK cycle of a releasing upper-half read.
    step(1'b0, 16'h0, 1'b1, 1'b0, 2'b00);
    fill4(16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 2'b10);
    step(1'b0, 16'h0, 1'b0, 1'b0, 2'b00);
    chk("simul_in_ack", 64'(bus.rd_ack), 64'd1);
    step(1'b1, 16'hAAAA, 1'b0, 1'b0, 2'b00);
    snap = bus.ob_data;
    chk("simul_count", 64'(bus.ob_count), 64'd1);
    chk("simul_lane0", 64'(snap[15:0]), 64'hAAAA);
    chk("simul_upper", 64'(snap[63:16]), 64'hdef0_9abc_5678);

    // Asynchronous reset during R_SEL with two lanes filled.
    step(1'b0, 16'h0, 1'b1, 1'b0, 2'b00);
    step(1'b1, 16'h0aa0, 1'b0, 1'b0, 2'b00);
    step(1'b1, 16'h0bb0, 1'b0, 1'b0, 2'b00);
    step(1'b0, 16'h0, 1'b0, 1'b1, 2'b01);
    chk("prerst_mux", 64'(bus.mux_sel), 64'h1);
    #2;
    bus.rd_req = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_mux", 64'(bus.mux_sel), 64'd0);
    chk("arst_ack", 64'(bus.rd_ack), 64'd0);
    chk("arst_count", 64'(bus.ob_count), 64'd0);
    chk("arst_data", bus.ob_data, 64'd0);
    chk("arst_flags", 64'({bus.sa_hold, bus.ob_full, bus.overflow}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b0, 2'b00);
      if (bus.rd_ack === 1'b1) nack++;
    end
    chk("arst_no_ack", 64'(nack), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
    end
    repeat (5) step(1'b0, 16'h0, 1'b0, 1'b0, 2'b00);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
